// File: rtl/resto5_scheduler.sv
// Round-robin scheduler sharing one combinational Resto5 (4-bit word mod 5) among N_REQ requesters.
// Each winner's word is registered, reduced, and returned on a valid/ready port tagged with its index.
module resto5_scheduler #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = $clog2(N_REQ),
  parameter int unsigned CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [4*N_REQ-1:0]      req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    res_valid,
  output logic [2:0]              res_data,
  output logic [ID_W-1:0]         res_id,
  input  logic                    res_ready,
  output logic                    busy,
  output logic [CNT_W-1:0]        done_cnt
);

  localparam int unsigned WORD_W = 4;
  localparam int unsigned RES_W  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [WORD_W-1:0]   operand_q, operand_d;
  logic                res_valid_q, res_valid_d;
  logic [RES_W-1:0]    res_data_q, res_data_d;
  logic [ID_W-1:0]     res_id_q, res_id_d;
  logic                busy_q, busy_d;
  logic [CNT_W-1:0]    done_cnt_q, done_cnt_d;

  logic [WORD_W-1:0]   word [N_REQ];
  logic                grant_found;
  logic [ID_W-1:0]     grant_idx;
  logic [ID_W-1:0]     cand;
  logic [N_REQ-1:0]    req_ready_c;
  logic [RES_W-1:0]    resto5_c;

  for (genvar g = 0; g < N_REQ; g++) begin : g_word
    assign word[g] = req_data[WORD_W*g +: WORD_W];
  end

  // Resto5: remainder of the registered sensor word modulo 5, {R1,R2,R3}
  assign resto5_c = RES_W'(operand_q % WORD_W'(5));

  // Round-robin winner: first valid requester scanning upward from rr_ptr
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = ID_W'((32'(rr_ptr_q) + k) % N_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    operand_d   = operand_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;
    done_cnt_d  = done_cnt_q;
    req_ready_c = '0;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          req_ready_c[grant_idx] = 1'b1;
          operand_d = word[grant_idx];
          res_id_d  = grant_idx;
          rr_ptr_d  = ID_W'((32'(grant_idx) + 32'd1) % N_REQ);
          state_d   = CALC;
        end
      end
      CALC: begin
        res_data_d  = resto5_c;
        res_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          done_cnt_d  = done_cnt_q + CNT_W'(1);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      operand_q   <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= '0;
      busy_q      <= 1'b0;
      done_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      operand_q   <= operand_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
      busy_q      <= busy_d;
      done_cnt_q  <= done_cnt_d;
    end
  end

  // Grant is combinational, so it is masked while reset is asserted
  assign req_ready = rst_n ? req_ready_c : '0;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;
  assign busy      = busy_q;
  assign done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_resto5_scheduler.sv
// Randomized bench for resto5_scheduler against an arithmetic round-robin / mod-5 reference model.
module tb_resto5_scheduler;
  localparam int unsigned N_REQ = 4;
  localparam int unsigned ID_W  = 2;
  localparam int unsigned CNT_W = 8;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [N_REQ-1:0]   req_valid;
  logic [4*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_ready;
  logic               res_valid;
  logic [2:0]         res_data;
  logic [ID_W-1:0]    res_id;
  logic               res_ready;
  logic               busy;
  logic [CNT_W-1:0]   done_cnt;

  int checks   = 0;
  int failures = 0;
  int m_rr     = 0;
  int m_done   = 0;

  resto5_scheduler #(.N_REQ(N_REQ), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .res_valid(res_valid), .res_data(res_data),
    .res_id(res_id), .res_ready(res_ready), .busy(busy), .done_cnt(done_cnt)
  );

  always #5 clk = ~clk;

  // Reference arbitration: first pending requester at or after the model pointer
  function automatic int model_winner(input logic [N_REQ-1:0] v);
    for (int k = 0; k < N_REQ; k++) begin
      int idx;
      idx = (m_rr + k) % N_REQ;
      if (v[idx[ID_W-1:0]]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input int i);
    logic [N_REQ-1:0] one;
    one = N_REQ'(1);
    return one << i;
  endfunction

  function automatic logic [2:0] rem5(input logic [3:0] w);
    return 3'(int'(w) % 5);
  endfunction

  function automatic logic [3:0] word_of(input int i);
    return req_data[i*4 +: 4];
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0; req_valid = '0; res_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    m_rr = 0; m_done = 0;
  endtask

  // Drives one transaction from an IDLE negedge; returns grant, result and grant-to-valid latency
  task automatic observe_txn(input int hold, output logic [N_REQ-1:0] gnt,
                             output logic [2:0] data, output logic [ID_W-1:0] id, output int lat);
    lat = -1;
    res_ready = 1'b0;
    #1;
    gnt = req_ready;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) req_valid = req_valid & ~gnt;
      if (res_valid) begin lat = c; break; end
    end
    data = res_data;
    id   = res_id;
    repeat (hold) @(negedge clk);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [N_REQ+1+3+ID_W+1+CNT_W-1:0] obs;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_valid = N_REQ'($urandom); req_data = 16'($urandom); res_ready = 1'($urandom);
      @(negedge clk); #1;
      obs = {req_ready, res_valid, res_data, res_id, busy, done_cnt};
      checks++;
      if (obs !== '0) begin failures++; $display("FAIL reset_hold: got %0h expected 0", obs); end
    end
    req_valid = '0; res_ready = 1'b0;
    @(posedge clk); #3 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      obs = {req_ready, res_valid, res_data, res_id, busy, done_cnt};
      checks++;
      if (obs !== '0) begin failures++; $display("FAIL reset_release: got %0h expected 0", obs); end
    end
    m_rr = 0; m_done = 0;
  endtask

  task automatic test_single();
    logic [N_REQ-1:0] gnt; logic [2:0] d; logic [ID_W-1:0] id; int lat;
    req_data = {12'($urandom), 4'b0110};
    req_valid = 4'b0001;
    observe_txn(0, gnt, d, id, lat);
    m_rr = 1; m_done = m_done + 1;
    checks++;
    if (gnt !== 4'b0001) begin failures++; $display("FAIL single_grant: got %b expected 0001", gnt); end
    checks++;
    if (lat != 2) begin failures++; $display("FAIL single_latency: got %0d expected 2", lat); end
    checks++;
    if (d !== rem5(4'b0110) || id !== 2'd0)
      begin failures++; $display("FAIL single_result: got %b/%0d expected %b/0", d, id, rem5(4'b0110)); end
    checks++;
    if (done_cnt !== CNT_W'(m_done) || busy !== 1'b0)
      begin failures++; $display("FAIL single_done: got cnt=%0d busy=%b expected cnt=%0d busy=0", done_cnt, busy, m_done); end
  endtask

  task automatic test_vectors();
    logic [3:0] vec [5];
    logic [N_REQ-1:0] gnt; logic [2:0] d; logic [ID_W-1:0] id; int lat, ew;
    vec = '{4'b0110, 4'b1101, 4'b1010, 4'b0011, 4'b1001};
    for (int i = 0; i < 5; i++) begin
      req_data[3:0] = vec[i];
      req_valid = 4'b0001;
      ew = model_winner(req_valid);
      observe_txn(0, gnt, d, id, lat);
      m_rr = (ew + 1) % N_REQ; m_done = (m_done + 1) % 256;
      checks++;
      if (gnt !== onehot(ew) || d !== rem5(vec[i]) || id !== ID_W'(ew))
        begin failures++; $display("FAIL vector_%0d: got gnt=%b res=%b id=%0d expected gnt=%b res=%b id=%0d",
                                   i, gnt, d, id, onehot(ew), rem5(vec[i]), ew); end
    end
    checks++;
    if (done_cnt !== CNT_W'(m_done)) begin failures++; $display("FAIL vector_count: got %0d expected %0d", done_cnt, m_done); end
  endtask

  task automatic test_round_robin();
    logic [N_REQ-1:0] gnt; logic [2:0] d; logic [ID_W-1:0] id; int lat, ew;
    logic [2:0] er;
    apply_reset();
    req_data  = {4'b1001, 4'b0011, 4'b1010, 4'b1101};
    req_valid = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      if (i == 4) req_valid = 4'b1001;
      ew = model_winner(req_valid);
      er = rem5(word_of(ew));
      observe_txn(0, gnt, d, id, lat);
      m_rr = (ew + 1) % N_REQ; m_done = (m_done + 1) % 256;
      checks++;
      if (gnt !== onehot(ew) || d !== er || id !== ID_W'(ew))
        begin failures++; $display("FAIL rr_step_%0d: got gnt=%b res=%b id=%0d expected gnt=%b res=%b id=%0d",
                                   i, gnt, d, id, onehot(ew), er, ew); end
    end
  endtask

  task automatic test_backpressure();
    logic [N_REQ-1:0] gnt; logic [2:0] d; logic [ID_W-1:0] id; int lat, r, o, ew, to;
    logic [3:0] w;
    logic [N_REQ+1+3+ID_W+1-1:0] obs, exp_obs;
    r = int'($urandom % N_REQ); o = (r + 1) % N_REQ; w = 4'($urandom);
    req_data[r*4 +: 4] = w;
    req_valid = onehot(r);
    res_ready = 1'b0;
    ew = model_winner(req_valid);
    #1;
    checks++;
    if (req_ready !== onehot(ew)) begin failures++; $display("FAIL bp_grant: got %b expected %b", req_ready, onehot(ew)); end
    m_rr = (ew + 1) % N_REQ;
    @(negedge clk);
    req_valid = onehot(o);
    req_data[o*4 +: 4] = 4'($urandom);
    to = 1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (res_valid) begin to = 0; break; end
    end
    checks++;
    if (to != 0) begin failures++; $display("FAIL bp_valid_timeout: got no res_valid expected res_valid within 8 cycles"); end
    exp_obs = {4'b0000, 1'b1, rem5(w), ID_W'(ew), 1'b1};
    for (int c = 0; c < 5; c++) begin
      obs = {req_ready, res_valid, res_data, res_id, busy};
      checks++;
      if (obs !== exp_obs) begin failures++; $display("FAIL bp_hold_%0d: got %h expected %h", c, obs, exp_obs); end
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    m_done = (m_done + 1) % 256;
    checks++;
    if (done_cnt !== CNT_W'(m_done) || res_valid !== 1'b0)
      begin failures++; $display("FAIL bp_accept: got cnt=%0d valid=%b expected cnt=%0d valid=0", done_cnt, res_valid, m_done); end
    ew = model_winner(req_valid);
    w  = word_of(ew);
    observe_txn(0, gnt, d, id, lat);
    m_rr = (ew + 1) % N_REQ; m_done = (m_done + 1) % 256;
    checks++;
    if (gnt !== onehot(ew) || d !== rem5(w) || id !== ID_W'(ew))
      begin failures++; $display("FAIL bp_pending: got gnt=%b res=%b id=%0d expected gnt=%b res=%b id=%0d",
                                 gnt, d, id, onehot(ew), rem5(w), ew); end
  endtask

  task automatic test_random();
    logic [N_REQ-1:0] gnt; logic [2:0] d; logic [ID_W-1:0] id; int lat, ew, bad;
    logic [3:0] w;
    bad = 0;
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N_REQ; i++)
        if (!req_valid[i] && ($urandom % 2 == 0)) begin
          req_data[i*4 +: 4] = 4'($urandom);
          req_valid[i] = 1'b1;
        end
      if (req_valid == '0) begin req_data[3:0] = 4'($urandom); req_valid[0] = 1'b1; end
      ew = model_winner(req_valid);
      w  = word_of(ew);
      observe_txn(int'($urandom % 3), gnt, d, id, lat);
      m_rr = (ew + 1) % N_REQ; m_done = (m_done + 1) % 256;
      checks++;
      if (gnt !== onehot(ew) || lat != 2 || d !== rem5(w) || id !== ID_W'(ew)) begin
        failures++;
        $display("FAIL random_%0d: got gnt=%b lat=%0d res=%b id=%0d expected gnt=%b lat=2 res=%b id=%0d",
                 t, gnt, lat, d, id, onehot(ew), rem5(w), ew);
      end
    end
    while (req_valid != '0) begin
      ew = model_winner(req_valid);
      observe_txn(0, gnt, d, id, lat);
      m_rr = (ew + 1) % N_REQ; m_done = (m_done + 1) % 256;
      bad++;
      if (bad > 8) req_valid = '0;
    end
    checks++;
    if (done_cnt !== CNT_W'(m_done)) begin failures++; $display("FAIL random_count: got %0d expected %0d", done_cnt, m_done); end
  endtask

  task automatic test_wrap();
    logic [N_REQ-1:0] gnt; logic [2:0] d; logic [ID_W-1:0] id; int lat, r;
    apply_reset();
    for (int t = 1; t <= 256; t++) begin
      r = int'($urandom % N_REQ);
      req_data[r*4 +: 4] = 4'($urandom);
      req_valid = onehot(r);
      observe_txn(0, gnt, d, id, lat);
      m_rr = (r + 1) % N_REQ; m_done = (m_done + 1) % 256;
      if (t == 255) begin
        checks++;
        if (done_cnt !== 8'hFF) begin failures++; $display("FAIL wrap_max: got %0d expected 255", done_cnt); end
      end
    end
    checks++;
    if (done_cnt !== CNT_W'(m_done) || m_done != 0)
      begin failures++; $display("FAIL wrap_zero: got %0d expected 0", done_cnt); end
  endtask

  task automatic test_reset_mid_calc();
    logic [N_REQ-1:0] gnt; logic [2:0] d; logic [ID_W-1:0] id; int lat, ew;
    apply_reset();
    req_data[3:0] = 4'b1101;
    req_valid = 4'b0001;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin failures++; $display("FAIL midrst_grant: got %b expected 0001", req_ready); end
    @(negedge clk);
    req_valid = '0;
    rst_n = 1'b0;
    m_rr = 0; m_done = 0;
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0) begin failures++; $display("FAIL midrst_in_reset: got valid=%b expected 0", res_valid); end
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if ({res_valid, busy, done_cnt} !== '0)
        begin failures++; $display("FAIL midrst_after_%0d: got valid=%b busy=%b cnt=%0d expected 0/0/0", c, res_valid, busy, done_cnt); end
    end
    req_data = {4'($urandom), 8'($urandom), 4'($urandom)};
    req_valid = 4'b1001;
    ew = model_winner(req_valid);
    observe_txn(0, gnt, d, id, lat);
    m_rr = (ew + 1) % N_REQ; m_done = (m_done + 1) % 256;
    checks++;
    if (gnt !== onehot(ew) || id !== ID_W'(ew))
      begin failures++; $display("FAIL midrst_ptr: got gnt=%b id=%0d expected gnt=%b id=%0d", gnt, id, onehot(ew), ew); end
    while (req_valid != '0) begin
      ew = model_winner(req_valid);
      observe_txn(0, gnt, d, id, lat);
      m_rr = (ew + 1) % N_REQ; m_done = (m_done + 1) % 256;
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; req_data = '0; res_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_vectors();
    test_round_robin();
    test_backpressure();
    test_random();
    test_wrap();
    test_reset_mid_calc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so a stuck design still produces a summary
  initial begin
    #200000;
    failures++;
    $display("FAIL timeout: got no completion expected finish before 200000");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
